// File: rtl/led_ctrl_pkg.sv
// rtl/led_ctrl_pkg.sv - shared encodings and helpers for the LED mode scheduler
// Contents: mode encoding, speed limit, initial FLOW/BLINK patterns, mode-advance order.
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_MANUAL = 2'd1,
        MODE_FLOW   = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_e;

    localparam logic [1:0] SPEED_MAX  = 2'd3;
    localparam logic [3:0] FLOW_INIT  = 4'b0001;
    localparam logic [3:0] BLINK_INIT = 4'b1111;

    // Advance order: MANUAL -> FLOW -> BLINK -> OFF -> MANUAL
    function automatic mode_e next_mode(input mode_e m);
        case (m)
            MODE_MANUAL: return MODE_FLOW;
            MODE_FLOW:   return MODE_BLINK;
            MODE_BLINK:  return MODE_OFF;
            default:     return MODE_MANUAL;
        endcase
    endfunction

endpackage

// File: rtl/led_step_timer.sv
// rtl/led_step_timer.sv - programmable step timer, period TICK_BASE >> speed
// Ports:
//   clk, rstn  clock, asynchronous active-low reset
//   run        count enable; when low the count holds
//   clr        synchronous clear, wins over run
//   speed      0 slowest .. 3 fastest
//   step       one-cycle pulse while the count sits at its last value and run is high
module led_step_timer
    import led_ctrl_pkg::*;
#(
    parameter int TICK_BASE = 50_000_000,
    parameter int CNT_W     = 26
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       run,
    input  logic       clr,
    input  logic [1:0] speed,
    output logic       step
);

    localparam logic [CNT_W-1:0] BASE = CNT_W'(TICK_BASE);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] last;

    assign last = (BASE >> speed) - CNT_W'(1);
    assign step = run && (cnt_q == last);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (run) begin
            cnt_q <= step ? '0 : cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/led_mode_sched.sv
// rtl/led_mode_sched.sv - LED mode/pattern scheduler driven by debounced key pulses
// Ports:
//   clk, rstn  clock, asynchronous active-low reset
//   key_pulse  [0] speed up / toggle bit0, [1] speed down / toggle bit1,
//              [2] pause / toggle bit2, [3] mode advance (overrides the rest)
//   led        registered LED drive, 1 = on
//   mode       0 OFF, 1 MANUAL, 2 FLOW, 3 BLINK
//   speed      0 slowest .. 3 fastest
//   paused     FLOW/BLINK stepping frozen
module led_mode_sched
    import led_ctrl_pkg::*;
#(
    parameter int TICK_BASE = 50_000_000,
    parameter int CNT_W     = 26
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [3:0] key_pulse,
    output logic [3:0] led,
    output logic [1:0] mode,
    output logic [1:0] speed,
    output logic       paused
);

    mode_e      mode_q, mode_nxt;
    logic [1:0] speed_nxt;
    logic       paused_nxt;
    logic [2:0] manual_q, manual_nxt;
    logic [3:0] pattern_q, pattern_nxt;
    logic [3:0] led_nxt;
    logic       stepping;
    logic       tmr_run;
    logic       tmr_clr;
    logic       step;

    assign mode     = mode_q;
    assign stepping = (mode_q == MODE_FLOW) || (mode_q == MODE_BLINK);
    assign tmr_run  = stepping && !paused;

    led_step_timer #(
        .TICK_BASE (TICK_BASE),
        .CNT_W     (CNT_W)
    ) u_timer (
        .clk   (clk),
        .rstn  (rstn),
        .run   (tmr_run),
        .clr   (tmr_clr),
        .speed (speed),
        .step  (step)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mode_q    <= MODE_MANUAL;
            speed     <= 2'd0;
            paused    <= 1'b0;
            manual_q  <= 3'b000;
            pattern_q <= 4'b0000;
            led       <= 4'b0000;
        end else begin
            mode_q    <= mode_nxt;
            speed     <= speed_nxt;
            paused    <= paused_nxt;
            manual_q  <= manual_nxt;
            pattern_q <= pattern_nxt;
            led       <= led_nxt;
        end
    end

    always_comb begin
        mode_nxt    = mode_q;
        speed_nxt   = speed;
        paused_nxt  = paused;
        manual_nxt  = manual_q;
        pattern_nxt = pattern_q;
        tmr_clr     = 1'b0;
        led_nxt     = 4'b0000;

        if (key_pulse[3]) begin
            // Mode change restarts the timer and reloads the pattern; a
            // coincident step is dropped because the pattern is overwritten.
            mode_nxt   = next_mode(mode_q);
            paused_nxt = 1'b0;
            tmr_clr    = 1'b1;
            case (mode_nxt)
                MODE_FLOW:  pattern_nxt = FLOW_INIT;
                MODE_BLINK: pattern_nxt = BLINK_INIT;
                default:    pattern_nxt = 4'b0000;
            endcase
        end else begin
            case (mode_q)
                MODE_MANUAL: begin
                    manual_nxt = manual_q ^ key_pulse[2:0];
                    tmr_clr    = 1'b1;
                end
                MODE_FLOW, MODE_BLINK: begin
                    // Saturated presses are no-ops and must not restart the count.
                    if (key_pulse[0] && !key_pulse[1] && speed != SPEED_MAX) begin
                        speed_nxt = speed + 2'd1;
                        tmr_clr   = 1'b1;
                    end else if (key_pulse[1] && !key_pulse[0] && speed != 2'd0) begin
                        speed_nxt = speed - 2'd1;
                        tmr_clr   = 1'b1;
                    end
                    if (key_pulse[2]) begin
                        paused_nxt = !paused;
                    end
                    if (step) begin
                        pattern_nxt = (mode_q == MODE_FLOW) ? {pattern_q[2:0], pattern_q[3]}
                                                            : ~pattern_q;
                    end
                end
                default: begin
                    tmr_clr = 1'b1;
                end
            endcase
        end

        // LED register follows the next state so key effects appear one edge later.
        case (mode_nxt)
            MODE_MANUAL:           led_nxt = {1'b0, manual_nxt};
            MODE_FLOW, MODE_BLINK: led_nxt = pattern_nxt;
            default:               led_nxt = 4'b0000;
        endcase
    end

endmodule
